// File: rtl/decodificador_display_multiplexado.sv
// rtl/decodificador_display_multiplexado.sv - 4-digit multiplexed 7-segment driver with blink
// Optional leading-zero blanking: define SUPRIME_ZEROS_EN.
module decodificador_display_multiplexado #(
  parameter int DIV       = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digitos,
  input  logic        enablen,
  input  logic        piscar,
  output logic [6:0]  segmentos,
  output logic [3:0]  anodos
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int QW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [QW-1:0] quadro_q, quadro_d;
  logic          fase_q, fase_d;
  logic [15:0]   sombra_q, sombra_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          cnt_wrap;
  logic          frame_end;
  logic [3:0]    digito;
  logic [6:0]    padrao;
  logic          apagado;

  always_comb begin
    cnt_wrap  = (cnt_q == CW'(DIV - 1));
    frame_end = cnt_wrap && (idx_q == 2'd3);
    digito    = sombra_q[4*idx_q +: 4];

    case (digito)
      4'd0:    padrao = 7'b1111110;
      4'd1:    padrao = 7'b0110000;
      4'd2:    padrao = 7'b1101101;
      4'd3:    padrao = 7'b1111001;
      4'd4:    padrao = 7'b0110011;
      4'd5:    padrao = 7'b1011011;
      4'd6:    padrao = 7'b1011111;
      4'd7:    padrao = 7'b1110000;
      4'd8:    padrao = 7'b1111111;
      4'd9:    padrao = 7'b1111011;
      default: padrao = 7'b0000001;
    endcase

`ifdef SUPRIME_ZEROS_EN
    // A slot is blank when it and every digit to its left are zero; digit 0 always shows.
    case (idx_q)
      2'd3:    apagado = (sombra_q[15:12] == 4'd0);
      2'd2:    apagado = (sombra_q[15:8] == 8'd0);
      2'd1:    apagado = (sombra_q[15:4] == 12'd0);
      default: apagado = 1'b0;
    endcase
`else
    apagado = 1'b0;
`endif

    if (enablen || (piscar && fase_q) || apagado) begin
      an_d  = 4'b1111;
      seg_d = 7'b0000000;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = padrao;
    end

    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
    sombra_d = frame_end ? digitos : sombra_q;
    quadro_d = quadro_q;
    fase_d   = fase_q;
    if (frame_end) begin
      if (quadro_q == QW'(BLINK_DIV - 1)) begin
        quadro_d = '0;
        fase_d   = ~fase_q;
      end else begin
        quadro_d = quadro_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      quadro_q <= '0;
      fase_q   <= 1'b0;
      sombra_q <= digitos;
      seg_q    <= 7'b0000000;
      an_q     <= 4'b1111;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      quadro_q <= quadro_d;
      fase_q   <= fase_d;
      sombra_q <= sombra_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign segmentos = seg_q;
  assign anodos    = an_q;

endmodule
